// File: rtl/game_2048_pkg.sv
// Shared types, geometry constants and the cell traversal helper for the 2048 engine.
package game_2048_pkg;

  localparam int CELL_W  = 16;
  localparam int EXP_W   = 4;
  localparam int N_CELLS = 16;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SLIDE,
    ST_SPAWN,
    ST_COMMIT
  } state_t;

  // Board index of the pos-th cell (pos 0 = lead cell) of a line, row-major board.
  function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] line,
                                          input logic [1:0] pos);
    logic [3:0] idx;
    case (dir)
      DIR_UP:   idx = {pos, line};
      DIR_DOWN: idx = {~pos, line};
      DIR_LEFT: idx = {line, pos};
      default:  idx = {line, ~pos};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/line_merge4.sv
// Combinational slide+merge of one 4-cell line, lead cell first; zero latency, no flow control.
module line_merge4
  import game_2048_pkg::*;
(
  input  logic [3:0][EXP_W-1:0] i_cells,
  output logic [3:0][EXP_W-1:0] o_cells,
  output logic                  o_changed,
  output logic [16:0]           o_score_inc
);

  logic [EXP_W-1:0] w_comp [5];
  logic [2:0]       w_ci;
  logic [1:0]       w_mi;
  logic             w_skip;

  always_comb begin
    w_comp = '{default: '0};
    w_ci   = '0;
    for (int p = 0; p < 4; p++) begin
      if (i_cells[p] != '0) begin
        w_comp[w_ci] = i_cells[p];
        w_ci         = w_ci + 3'd1;
      end
    end

    // Merge and recompress in one pass; w_comp[4] stays zero so it never pairs.
    o_cells     = '0;
    o_score_inc = '0;
    w_mi        = '0;
    w_skip      = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (w_skip) begin
        w_skip = 1'b0;
      end else if (w_comp[p] != '0) begin
        if (w_comp[p] == w_comp[p+1] && w_comp[p] != '1) begin
          o_cells[w_mi] = w_comp[p] + 4'd1;
          o_score_inc   = o_score_inc + (17'd1 << (w_comp[p] + 4'd1));
          w_skip        = 1'b1;
        end else begin
          o_cells[w_mi] = w_comp[p];
        end
        w_mi = w_mi + 2'd1;
      end
    end
  end

  assign o_changed = (o_cells != i_cells);

endmodule

// File: rtl/game_2048_engine.sv
// 2048 board engine: one move per handshake, 4 slide cycles + 1..16 spawn cycles + 1 commit.
// move_ready only in IDLE and not game over; requests elsewhere are dropped, never queued.
module game_2048_engine
  import game_2048_pkg::*;
#(
  parameter int unsigned SCORE_W   = 16,
  parameter int unsigned WIN_EXP   = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               move_valid,
  input  logic [1:0]         move_dir,
  output logic               move_ready,
  input  logic               load_en,
  input  logic [0:255]       load_board,
  output logic [0:255]       board_state,
  output logic               move_done,
  output logic               moved,
  output logic [SCORE_W-1:0] score,
  output logic               win,
  output logic               game_over
);

  localparam int SUM_W = SCORE_W + 21;

  state_t             r_state, w_state_nxt;
  logic [EXP_W-1:0]   r_work  [N_CELLS];
  logic [EXP_W-1:0]   r_board [N_CELLS];
  logic [EXP_W-1:0]   w_load_cell [N_CELLS];
  logic [1:0]         r_dir, r_line;
  logic               r_changed_any, r_first, r_init, r_spawn_n;
  logic [3:0]         r_ptr;
  logic [19:0]        r_pend;
  logic [15:0]        r_lfsr;
  logic [SCORE_W-1:0] r_score;
  logic               r_win, r_game_over, r_done, r_moved;

  logic               w_ready, w_load, w_accept, w_hit, w_last_line, w_fb;
  logic               w_changed, w_win, w_go;
  logic [3:0]         w_ptr;
  logic [EXP_W-1:0]   w_tile;
  logic [3:0][EXP_W-1:0] w_line_in, w_line_out;
  logic [16:0]        w_inc;
  logic [SUM_W-1:0]   w_sum;

  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_ready     = (r_state == ST_IDLE) && !r_game_over;
  assign w_load      = w_ready && load_en;
  assign w_accept    = w_ready && !load_en && move_valid;
  assign w_ptr       = r_first ? r_lfsr[3:0] : r_ptr;
  assign w_hit       = (r_work[w_ptr] == '0);
  assign w_tile      = (r_lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
  assign w_last_line = (r_line == 2'd3);
  assign w_sum       = SUM_W'(r_score) + SUM_W'(r_pend);

  always_comb begin
    w_line_in = '0;
    for (int p = 0; p < 4; p++) begin
      w_line_in[p] = r_work[cell_idx(r_dir, r_line, 2'(p))];
    end
  end

  line_merge4 u_line_merge4 (
    .i_cells     (w_line_in),
    .o_cells     (w_line_out),
    .o_changed   (w_changed),
    .o_score_inc (w_inc)
  );

  // A loaded value that does not fit the exponent field clamps to the largest tile.
  always_comb begin
    for (int i = 0; i < N_CELLS; i++) begin
      w_load_cell[i] = (|load_board[CELL_W*i +: CELL_W-EXP_W]) ? '1
                                                              : load_board[CELL_W*i+CELL_W-EXP_W +: EXP_W];
    end
  end

  always_comb begin
    w_win = 1'b0;
    w_go  = 1'b1;
    for (int i = 0; i < N_CELLS; i++) begin
      if (r_board[i] == '0) w_go = 1'b0;
      if (32'(r_board[i]) >= WIN_EXP) w_win = 1'b1;
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (r_board[r*4+c] == r_board[r*4+c+1]) w_go = 1'b0;
      end
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r_board[r*4+c] == r_board[r*4+c+4]) w_go = 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:   w_state_nxt = ST_SPAWN;
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SLIDE;
      ST_SLIDE:  if (w_last_line) w_state_nxt = (r_changed_any || w_changed) ? ST_SPAWN : ST_IDLE;
      ST_SPAWN:  if (w_hit && !(r_init && !r_spawn_n)) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= ST_INIT;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < N_CELLS; i++) begin
        r_work[i]  <= '0;
        r_board[i] <= '0;
      end
      r_dir         <= '0;
      r_line        <= '0;
      r_changed_any <= 1'b0;
      r_first       <= 1'b0;
      r_init        <= 1'b0;
      r_spawn_n     <= 1'b0;
      r_ptr         <= '0;
      r_pend        <= '0;
      r_lfsr        <= LFSR_SEED;
      r_score       <= '0;
      r_win         <= 1'b0;
      r_game_over   <= 1'b0;
      r_done        <= 1'b0;
      r_moved       <= 1'b0;
    end else begin
      r_lfsr      <= {r_lfsr[14:0], w_fb};
      r_done      <= 1'b0;
      r_moved     <= 1'b0;
      r_game_over <= w_go;
      r_win       <= r_win | w_win;
      case (r_state)
        ST_INIT: begin
          for (int i = 0; i < N_CELLS; i++) r_work[i] <= '0;
          r_init    <= 1'b1;
          r_spawn_n <= 1'b0;
          r_first   <= 1'b1;
        end
        ST_IDLE: begin
          if (w_load) begin
            for (int i = 0; i < N_CELLS; i++) begin
              r_work[i]  <= w_load_cell[i];
              r_board[i] <= w_load_cell[i];
            end
          end else if (w_accept) begin
            for (int i = 0; i < N_CELLS; i++) r_work[i] <= r_board[i];
            r_dir         <= move_dir;
            r_line        <= '0;
            r_changed_any <= 1'b0;
            r_pend        <= '0;
          end
        end
        ST_SLIDE: begin
          for (int p = 0; p < 4; p++) r_work[cell_idx(r_dir, r_line, 2'(p))] <= w_line_out[p];
          r_line        <= r_line + 2'd1;
          r_changed_any <= r_changed_any | w_changed;
          r_pend        <= r_pend + 20'(w_inc);
          r_first       <= 1'b1;
          if (w_last_line && !(r_changed_any || w_changed)) r_done <= 1'b1;
        end
        ST_SPAWN: begin
          r_first <= 1'b0;
          if (w_hit) begin
            r_work[w_ptr] <= w_tile;
            if (r_init && !r_spawn_n) begin
              r_spawn_n <= 1'b1;
              r_first   <= 1'b1;
            end
          end else begin
            r_ptr <= w_ptr + 4'd1;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < N_CELLS; i++) r_board[i] <= r_work[i];
          r_done  <= 1'b1;
          r_moved <= !r_init;
          r_init  <= 1'b0;
          r_score <= (|w_sum[SUM_W-1:SCORE_W]) ? '1 : w_sum[SCORE_W-1:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    board_state = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      board_state[CELL_W*i+CELL_W-EXP_W +: EXP_W] = r_board[i];
    end
  end

  assign move_ready = w_ready;
  assign move_done  = r_done;
  assign moved      = r_moved;
  assign score      = r_score;
  assign win        = r_win;
  assign game_over  = r_game_over;

endmodule
